// File: rtl/lj_pair_feeder.sv
// lj_pair_feeder: accepts one particle pair per handshake, forms the
// j-i displacement and r^2, rejects pairs outside [R2_MIN, RC_SQ],
// derives 1/r^2 in Q16.16 with a 32-step restoring divider, and feeds
// r2_inv/sigma_sq/epsilon_x24 to the LJ core. A fixed-depth tracker
// turns r2_inv_valid/out_tag into f_valid/f_tag after LJ_LATENCY cycles.
// Ports:
//   clk, rst               clock, async active-high reset
//   in_valid/in_ready      pair handshake (ready only in IDLE)
//   xi..zj                 signed Q16.16 positions
//   sigma_sq_in, epsilon_x24_in, in_tag   per-pair parameters and id
//   r2_inv, sigma_sq, epsilon_x24, r2_inv_valid, out_tag   core feed
//   dx, dy, dz             displacement j - i
//   skip, skip_tag         rejected-pair pulse
//   f_valid, f_tag         core force valid for that pair
module lj_pair_feeder #(
   parameter logic [31:0] RC_SQ      = 32'h0009_0000,
   parameter logic [31:0] R2_MIN     = 32'h0000_4000,
   parameter int          LJ_LATENCY = 7,
   parameter int          TAG_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      xi,
   input  logic [31:0]      yi,
   input  logic [31:0]      zi,
   input  logic [31:0]      xj,
   input  logic [31:0]      yj,
   input  logic [31:0]      zj,
   input  logic [31:0]      sigma_sq_in,
   input  logic [31:0]      epsilon_x24_in,
   input  logic [TAG_W-1:0] in_tag,
   output logic [31:0]      r2_inv,
   output logic [31:0]      sigma_sq,
   output logic [31:0]      epsilon_x24,
   output logic             r2_inv_valid,
   output logic [31:0]      dx,
   output logic [31:0]      dy,
   output logic [31:0]      dz,
   output logic             skip,
   output logic [TAG_W-1:0] skip_tag,
   output logic [TAG_W-1:0] out_tag,
   output logic             f_valid,
   output logic [TAG_W-1:0] f_tag
);

   typedef enum logic [2:0] {
      S_IDLE, S_DIFF, S_SQ, S_CHECK, S_DIV, S_OUT
   } state_t;

   state_t state_q, state_d;
   logic [31:0] xi_q, yi_q, zi_q, xj_q, yj_q, zj_q;
   logic [31:0] xi_d, yi_d, zi_d, xj_d, yj_d, zj_d;
   logic [31:0] sig_in_q, eps_in_q, sig_in_d, eps_in_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic ovf_q, ovf_d;
   logic [31:0] dx_q, dy_q, dz_q, dx_d, dy_d, dz_d;
   logic [47:0] sqx_q, sqy_q, sqz_q, sqx_d, sqy_d, sqz_d;
   logic [31:0] r2_q, r2_d;
   logic [31:0] rem_q, rem_d;
   logic [30:0] quo_q, quo_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] r2_inv_q, sigma_q, eps_q;
   logic [31:0] r2_inv_d, sigma_d, eps_d;
   logic [TAG_W-1:0] out_tag_q, out_tag_d, skip_tag_q, skip_tag_d;
   logic valid_q, valid_d, skip_q, skip_d;
   logic [LJ_LATENCY-1:0] vsr_q, vsr_d;
   logic [LJ_LATENCY-1:0][TAG_W-1:0] tsr_q, tsr_d;

   // 33-bit differences; a pair is unusable if any one leaves int32
   logic [32:0] ddx, ddy, ddz;
   logic        diff_ovf;
   logic signed [63:0] px, py, pz;
   logic [49:0] r2_full;
   logic [32:0] rem_sh;
   logic [31:0] rem_sub;
   logic        qbit;

   always_comb begin
      ddx = {xj_q[31], xj_q} - {xi_q[31], xi_q};
      ddy = {yj_q[31], yj_q} - {yi_q[31], yi_q};
      ddz = {zj_q[31], zj_q} - {zi_q[31], zi_q};
      diff_ovf = (ddx[32] != ddx[31]) | (ddy[32] != ddy[31])
               | (ddz[32] != ddz[31]);
      px = $signed(dx_q) * $signed(dx_q);
      py = $signed(dy_q) * $signed(dy_q);
      pz = $signed(dz_q) * $signed(dz_q);
      r2_full = {2'b00, sqx_q} + {2'b00, sqy_q} + {2'b00, sqz_q};
      // remainder stays below the divisor, so 32 bits hold it
      rem_sh  = {rem_q, 1'b0};
      qbit    = rem_sh >= {1'b0, r2_q};
      rem_sub = 32'(rem_sh - {1'b0, r2_q});
   end

   always_comb begin
      state_d    = state_q;
      xi_d = xi_q; yi_d = yi_q; zi_d = zi_q;
      xj_d = xj_q; yj_d = yj_q; zj_d = zj_q;
      sig_in_d   = sig_in_q;
      eps_in_d   = eps_in_q;
      tag_d      = tag_q;
      ovf_d      = ovf_q;
      dx_d = dx_q; dy_d = dy_q; dz_d = dz_q;
      sqx_d = sqx_q; sqy_d = sqy_q; sqz_d = sqz_q;
      r2_d       = r2_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      cnt_d      = cnt_q;
      r2_inv_d   = r2_inv_q;
      sigma_d    = sigma_q;
      eps_d      = eps_q;
      out_tag_d  = out_tag_q;
      skip_tag_d = skip_tag_q;
      valid_d    = 1'b0;
      skip_d     = 1'b0;
      vsr_d      = {vsr_q[LJ_LATENCY-2:0], valid_q};
      tsr_d      = {tsr_q[LJ_LATENCY-2:0], out_tag_q};
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               xi_d = xi; yi_d = yi; zi_d = zi;
               xj_d = xj; yj_d = yj; zj_d = zj;
               sig_in_d = sigma_sq_in;
               eps_in_d = epsilon_x24_in;
               tag_d    = in_tag;
               state_d  = S_DIFF;
            end
         end
         S_DIFF: begin
            ovf_d = diff_ovf;
            if (!diff_ovf) begin
               dx_d = ddx[31:0];
               dy_d = ddy[31:0];
               dz_d = ddz[31:0];
            end
            state_d = S_SQ;
         end
         S_SQ: begin
            sqx_d   = 48'(px >>> 16);
            sqy_d   = 48'(py >>> 16);
            sqz_d   = 48'(pz >>> 16);
            state_d = S_CHECK;
         end
         S_CHECK: begin
            if (ovf_q || r2_full > {18'd0, RC_SQ}
                || r2_full < {18'd0, R2_MIN}) begin
               skip_d     = 1'b1;
               skip_tag_d = tag_q;
               state_d    = S_IDLE;
            end else begin
               r2_d = r2_full[31:0];
               // bit 32 of the dividend 2^32 is preloaded
               rem_d   = 32'd1;
               quo_d   = '0;
               cnt_d   = '0;
               state_d = S_DIV;
            end
         end
         S_DIV: begin
            quo_d = {quo_q[29:0], qbit};
            rem_d = qbit ? rem_sub : rem_sh[31:0];
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               r2_inv_d  = {quo_q, qbit};
               sigma_d   = sig_in_q;
               eps_d     = eps_in_q;
               out_tag_d = tag_q;
               valid_d   = 1'b1;
               state_d   = S_OUT;
            end
         end
         S_OUT: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         xi_q <= '0; yi_q <= '0; zi_q <= '0;
         xj_q <= '0; yj_q <= '0; zj_q <= '0;
         sig_in_q <= '0; eps_in_q <= '0; tag_q <= '0;
         ovf_q <= 1'b0;
         dx_q <= '0; dy_q <= '0; dz_q <= '0;
         sqx_q <= '0; sqy_q <= '0; sqz_q <= '0;
         r2_q <= '0; rem_q <= '0; quo_q <= '0; cnt_q <= '0;
         r2_inv_q <= '0; sigma_q <= '0; eps_q <= '0;
         out_tag_q <= '0; skip_tag_q <= '0;
         valid_q <= 1'b0; skip_q <= 1'b0;
         vsr_q <= '0; tsr_q <= '0;
      end else begin
         state_q <= state_d;
         xi_q <= xi_d; yi_q <= yi_d; zi_q <= zi_d;
         xj_q <= xj_d; yj_q <= yj_d; zj_q <= zj_d;
         sig_in_q <= sig_in_d; eps_in_q <= eps_in_d; tag_q <= tag_d;
         ovf_q <= ovf_d;
         dx_q <= dx_d; dy_q <= dy_d; dz_q <= dz_d;
         sqx_q <= sqx_d; sqy_q <= sqy_d; sqz_q <= sqz_d;
         r2_q <= r2_d; rem_q <= rem_d; quo_q <= quo_d; cnt_q <= cnt_d;
         r2_inv_q <= r2_inv_d; sigma_q <= sigma_d; eps_q <= eps_d;
         out_tag_q <= out_tag_d; skip_tag_q <= skip_tag_d;
         valid_q <= valid_d; skip_q <= skip_d;
         vsr_q <= vsr_d; tsr_q <= tsr_d;
      end
   end

   // held low while rst is asserted even though the state reads IDLE
   assign in_ready     = (state_q == S_IDLE) && !rst;
   assign r2_inv       = r2_inv_q;
   assign sigma_sq     = sigma_q;
   assign epsilon_x24  = eps_q;
   assign r2_inv_valid = valid_q;
   assign out_tag      = out_tag_q;
   assign dx           = dx_q;
   assign dy           = dy_q;
   assign dz           = dz_q;
   assign skip         = skip_q;
   assign skip_tag     = skip_tag_q;
   assign f_valid      = vsr_q[LJ_LATENCY-1];
   assign f_tag        = tsr_q[LJ_LATENCY-1];

endmodule

// File: tb/tb_lj_pair_feeder.sv
// tb_lj_pair_feeder: directed and randomized pairs checked against a
// cycle-indexed scoreboard built from plain longint arithmetic.
module tb_lj_pair_feeder;
   localparam logic [31:0] RC   = 32'h0009_0000;
   localparam logic [31:0] RMIN = 32'h0000_4000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic in_valid = 1'b0;
   logic in_ready;
   logic [31:0] xi = '0, yi = '0, zi = '0, xj = '0, yj = '0, zj = '0;
   logic [31:0] sigma_sq_in = '0, epsilon_x24_in = '0;
   logic [7:0]  in_tag = '0;
   logic [31:0] r2_inv, sigma_sq, epsilon_x24, dx, dy, dz;
   logic r2_inv_valid, skip, f_valid;
   logic [7:0] skip_tag, out_tag, f_tag;

   lj_pair_feeder dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .xi(xi), .yi(yi), .zi(zi), .xj(xj), .yj(yj), .zj(zj),
      .sigma_sq_in(sigma_sq_in), .epsilon_x24_in(epsilon_x24_in),
      .in_tag(in_tag), .r2_inv(r2_inv), .sigma_sq(sigma_sq),
      .epsilon_x24(epsilon_x24), .r2_inv_valid(r2_inv_valid),
      .dx(dx), .dy(dy), .dz(dz), .skip(skip), .skip_tag(skip_tag),
      .out_tag(out_tag), .f_valid(f_valid), .f_tag(f_tag)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string t, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", t, got, exp,
                  $time);
      end
   endtask

   typedef struct {
      logic [7:0]  tag;
      logic [31:0] inv, sig, eps, dx, dy, dz;
   } rec_t;

   rec_t       vq[int];
   logic [7:0] sq[int];
   logic [7:0] fq[int];
   int cyc = 0;
   int free_c = 0;
   int acc_cnt = 0;

   always @(posedge clk) cyc++;

   function automatic void model(input logic [31:0] a_xi, a_yi, a_zi,
                                 input logic [31:0] a_xj, a_yj, a_zj,
                                 output bit sk, output rec_t r);
      longint d[3];
      longint r2;
      bit ovf;
      d[0] = longint'($signed(a_xj)) - longint'($signed(a_xi));
      d[1] = longint'($signed(a_yj)) - longint'($signed(a_yi));
      d[2] = longint'($signed(a_zj)) - longint'($signed(a_zi));
      ovf = 0;
      r2 = 0;
      for (int k = 0; k < 3; k++)
         if (d[k] > 64'sd2147483647 || d[k] < -64'sd2147483648) ovf = 1;
      if (!ovf) for (int k = 0; k < 3; k++) r2 += (d[k] * d[k]) >>> 16;
      sk = ovf || r2 > longint'(RC) || r2 < longint'(RMIN);
      r.dx = 32'(d[0]);
      r.dy = 32'(d[1]);
      r.dz = 32'(d[2]);
      r.inv = sk ? 32'd0 : 32'((64'sd1 <<< 32) / r2);
      r.tag = '0; r.sig = '0; r.eps = '0;
   endfunction

   always @(negedge clk) begin
      bit   e, sk;
      rec_t r;
      int   a;
      if (rst) begin
         vq.delete(); sq.delete(); fq.delete();
         free_c = 0;
      end else begin
         chk("in_ready", in_ready, cyc >= free_c);
         e = sq.exists(cyc);
         chk("skip", skip, e);
         if (e) begin
            chk("skip_tag", skip_tag, sq[cyc]);
            sq.delete(cyc);
         end
         e = vq.exists(cyc);
         chk("r2_inv_valid", r2_inv_valid, e);
         if (e) begin
            r = vq[cyc];
            chk("r2_inv", r2_inv, r.inv);
            chk("sigma_sq", sigma_sq, r.sig);
            chk("epsilon_x24", epsilon_x24, r.eps);
            chk("out_tag", out_tag, r.tag);
            chk("dx", dx, r.dx);
            chk("dy", dy, r.dy);
            chk("dz", dz, r.dz);
            vq.delete(cyc);
         end
         e = fq.exists(cyc);
         chk("f_valid", f_valid, e);
         if (e) begin
            chk("f_tag", f_tag, fq[cyc]);
            fq.delete(cyc);
         end
         if (in_valid && cyc >= free_c) begin
            a = cyc + 1;
            model(xi, yi, zi, xj, yj, zj, sk, r);
            r.tag = in_tag; r.sig = sigma_sq_in; r.eps = epsilon_x24_in;
            if (sk) begin
               sq[a + 3] = in_tag;
               free_c = a + 3;
            end else begin
               vq[a + 35] = r;
               fq[a + 42] = in_tag;
               free_c = a + 36;
            end
            acc_cnt++;
         end
      end
   end

   task automatic at_edge(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] a_xi, a_yi, a_zi,
                       input logic [31:0] a_xj, a_yj, a_zj,
                       input logic [7:0] t);
      int n0;
      n0 = acc_cnt;
      xi = a_xi; yi = a_yi; zi = a_zi;
      xj = a_xj; yj = a_yj; zj = a_zj;
      sigma_sq_in = $urandom;
      epsilon_x24_in = $urandom;
      in_tag = t;
      in_valid = 1'b1;
      for (int k = 0; k < 200 && acc_cnt == n0; k++) at_edge(1);
      if (acc_cnt == n0) chk("accept_timeout", 0, 1);
   endtask

   task automatic chk_zero(input string t);
      chk({t, "_r2_inv"}, r2_inv, 0);
      chk({t, "_params"}, {sigma_sq, epsilon_x24}, 0);
      chk({t, "_dxyz"}, {dx, dy}, 0);
      chk({t, "_dz"}, dz, 0);
      chk({t, "_pulses"}, {r2_inv_valid, f_valid, skip}, 0);
      chk({t, "_tags"}, {out_tag, f_tag, skip_tag}, 0);
      chk({t, "_in_ready"}, in_ready, 0);
   endtask

   initial begin
      logic [31:0] b, dv[3];
      #1 rst = 1'b1;
      #1 chk_zero("reset");
      at_edge(2);
      rst = 1'b0;
      #1 chk("ready_after_rst", in_ready, 1);
      at_edge(1);

      // unit distance
      send(0, 0, 0, 32'h0001_0000, 0, 0, 8'h01);
      in_valid = 1'b0;
      at_edge(35);
      chk("unit_valid", r2_inv_valid, 1);
      chk("unit_inv", r2_inv, 32'h0001_0000);
      chk("unit_dx", dx, 32'h0001_0000);
      at_edge(7);
      chk("unit_fvalid", f_valid, 1);
      chk("unit_ftag", f_tag, 8'h01);
      at_edge(3);

      // negative displacement
      send(32'h0001_8000, 0, 0, 32'hFFFF_8000, 0, 0, 8'h02);
      in_valid = 1'b0;
      at_edge(35);
      chk("neg_dx", dx, 32'hFFFE_0000);
      chk("neg_inv", r2_inv, 32'h0000_4000);
      at_edge(10);

      // r^2 exactly at cutoff is accepted
      send(0, 0, 0, 32'h0003_0000, 0, 0, 8'h03);
      in_valid = 1'b0;
      at_edge(35);
      chk("cut_inv", r2_inv, 32'h0000_1C71);
      at_edge(10);

      // beyond cutoff
      send(0, 0, 0, 32'h0004_0000, 0, 0, 8'h04);
      in_valid = 1'b0;
      at_edge(3);
      chk("far_skip", skip, 1);
      chk("far_skip_tag", skip_tag, 8'h04);
      at_edge(3);

      // below minimum distance
      send(0, 0, 0, 32'h0000_3000, 0, 0, 8'h05);
      in_valid = 1'b0;
      at_edge(3);
      chk("near_skip", skip, 1);
      at_edge(3);

      // difference leaves int32
      send(32'h7FFF_0000, 0, 0, 32'h8000_0000, 0, 0, 8'h06);
      in_valid = 1'b0;
      at_edge(5);

      // back-pressure and overlap: second pair queued behind the first
      send(0, 0, 0, 0, 32'h0001_8000, 0, 8'h10);
      send(0, 0, 0, 0, 0, 32'hFFFF_0000, 8'h11);
      in_valid = 1'b0;
      at_edge(50);

      // reset in the middle of the divide
      send(0, 0, 0, 32'h0001_0000, 32'h0001_0000, 0, 8'h20);
      in_valid = 1'b0;
      at_edge(20);
      rst = 1'b1;
      #1 chk_zero("mid_rst");
      at_edge(2);
      rst = 1'b0;
      #1 chk("ready_after_mid_rst", in_ready, 1);
      send(0, 32'h0002_0000, 0, 0, 0, 0, 8'h21);
      in_valid = 1'b0;
      at_edge(45);

      // randomized pairs, sometimes back-to-back
      for (int n = 0; n < 40; n++) begin
         b = $urandom;
         for (int k = 0; k < 3; k++)
            dv[k] = 32'($urandom_range(0, 32'h50000)) - 32'h28000;
         send(b, ~b, b ^ 32'h1234_5678, b + dv[0], ~b + dv[1],
              (b ^ 32'h1234_5678) + dv[2], 8'(8'h40 + n));
         if ($urandom_range(0, 2) != 0) begin
            in_valid = 1'b0;
            at_edge($urandom_range(0, 3));
         end
      end
      in_valid = 1'b0;
      at_edge(60);
      chk("drained", vq.size() + sq.size() + fq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
